// File: rtl/hamming_stream_tx.sv
// hamming_stream_tx: feeds one operand pair into a CC-cycle hamming core and returns its distance.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/g_word/e_word accept an operand pair;
// core_rst/g_slice/e_slice drive the core (LSB slice first); core_o is the core distance;
// res_valid/res_ready/res_dist hand the captured distance to the consumer.
module hamming_stream_tx #(
  parameter int N = 8,
  parameter int CC = 1,
  parameter int CORE_LAT = 1,
  parameter int OW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      g_word,
  input  logic [N-1:0]      e_word,
  output logic              core_rst,
  output logic [N/CC-1:0]   g_slice,
  output logic [N/CC-1:0]   e_slice,
  input  logic [OW-1:0]     core_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OW-1:0]     res_dist
);
  localparam int M = N / CC;
  localparam int MX = CC > CORE_LAT ? CC : CORE_LAT;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [CW-1:0] SEND_LAST = CW'(CC - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(CORE_LAT - 1);
  if (N % CC != 0 || CORE_LAT < 1) begin : g_bad_params
    $error("hamming_stream_tx: N must be a multiple of CC and CORE_LAT must be >= 1");
  end
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, OUT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0] g_reg, e_reg;
  logic last;
  assign in_ready = state == IDLE;
  assign core_rst = rst || state == LOAD;
  assign res_valid = state == OUT;
  assign g_slice = state == SEND ? M'(g_reg >> (M * cnt)) : '0;
  assign e_slice = state == SEND ? M'(e_reg >> (M * cnt)) : '0;
  // one counter serves both the slice index in SEND and the latency count in WAIT
  assign last = state == SEND ? cnt == SEND_LAST : cnt == WAIT_LAST;
  always_comb begin
    state_nxt = state;
    cnt_nxt = '0;
    case (state)
      IDLE: state_nxt = in_valid ? LOAD : IDLE;
      LOAD: state_nxt = SEND;
      SEND: begin
        state_nxt = last ? WAIT : SEND;
        cnt_nxt = last ? '0 : cnt + CW'(1);
      end
      WAIT: begin
        state_nxt = last ? OUT : WAIT;
        cnt_nxt = last ? '0 : cnt + CW'(1);
      end
      OUT: state_nxt = res_ready ? IDLE : OUT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      g_reg <= '0;
      e_reg <= '0;
      res_dist <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      if (state == IDLE && in_valid) begin
        g_reg <= g_word;
        e_reg <= e_word;
      end
      if (state == WAIT && last) res_dist <= core_o;
    end
  end
endmodule

// File: tb/tb_hamming_stream_tx.sv
// tb_hamming_stream_tx: scoreboard bench driving a CC=1 and a CC=4 instance, each with a behavioural core.
module tb_hamming_stream_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic in_valid [2];
  logic res_ready [2];
  logic [7:0] g_word [2];
  logic [7:0] e_word [2];
  logic [7:0] g_sl [2];
  logic [7:0] e_sl [2];
  logic in_ready [2];
  logic core_rst [2];
  logic res_valid [2];
  logic [3:0] core_o [2];
  logic [3:0] res_dist [2];
  logic rv_d [2] = '{1'b0, 1'b0};
  int checks = 0;
  int failures = 0;
  int exp_q [2][$];
  int acc_q [2][$];
  for (genvar i = 0; i < 2; i++) begin : g_inst
    localparam int CC = i == 0 ? 1 : 4;
    localparam int M = 8 / CC;
    logic [M-1:0] gs, es;
    logic [3:0] acc;
    hamming_stream_tx #(.N(8), .CC(CC), .CORE_LAT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid[i]), .in_ready(in_ready[i]),
      .g_word(g_word[i]), .e_word(e_word[i]), .core_rst(core_rst[i]),
      .g_slice(gs), .e_slice(es), .core_o(core_o[i]), .res_valid(res_valid[i]),
      .res_ready(res_ready[i]), .res_dist(res_dist[i]));
    always @(posedge clk) acc <= core_rst[i] ? 4'd0 : acc + 4'($countones(gs ^ es));
    assign core_o[i] = acc;
    assign g_sl[i] = 8'(gs);
    assign e_sl[i] = 8'(es);
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && in_valid[i] && in_ready[i]) acc_q[i].push_back(cyc + 1);
      if (res_valid[i] && !rv_d[i] && acc_q[i].size() > 0)
        chk($sformatf("latency%0d", i), cyc - acc_q[i].pop_front(), (i == 0 ? 1 : 4) + 2);
      if (res_valid[i]) begin
        chk($sformatf("in_ready_busy%0d", i), int'(in_ready[i]), 0);
        if (exp_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result%0d: got res_valid=1 expected 0 (cycle %0d)", i, cyc);
        end else begin
          chk($sformatf("res_dist%0d", i), int'(res_dist[i]), exp_q[i][0]);
          if (res_ready[i]) void'(exp_q[i].pop_front());
        end
      end
      rv_d[i] <= res_valid[i];
    end
  end
  task automatic offer(input int i, input logic [7:0] g, input logic [7:0] e, input int exp);
    int n = 0;
    g_word[i] = g;
    e_word[i] = e;
    in_valid[i] = 1'b1;
    @(negedge clk);
    while (!in_ready[i] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("accept_timeout", n, 0);
    exp_q[i].push_back(exp);
    @(posedge clk);
    #1 in_valid[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge clk);
    while (!in_ready[i] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("idle_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask
  int gx [4] = '{1, 2, 2, 2};
  int ex [4] = '{3, 2, 3, 1};
  logic [7:0] bg [3] = '{8'hA9, 8'h74, 8'h00};
  logic [7:0] be [3] = '{8'h7B, 8'h9D, 8'hFF};
  int bx [3] = '{4, 5, 8};
  initial begin
    int n, prev;
    in_valid = '{1'b0, 1'b0};
    res_ready = '{1'b1, 1'b1};
    g_word = '{8'h00, 8'h00};
    e_word = '{8'h00, 8'h00};
    @(posedge clk);
    @(negedge clk);
    chk("rst_core_rst0", int'(core_rst[0]), 1);
    chk("rst_core_rst1", int'(core_rst[1]), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_in_ready", int'(in_ready[i]), 1);
      chk("reset_core_rst", int'(core_rst[i]), 0);
      chk("reset_res_valid", int'(res_valid[i]), 0);
      chk("reset_res_dist", int'(res_dist[i]), 0);
      chk("reset_g_slice", int'(g_sl[i]), 0);
      chk("reset_e_slice", int'(e_sl[i]), 0);
    end
    @(posedge clk);
    #1;
    offer(0, 8'hA9, 8'h7B, 4);
    wait_idle(0);
    offer(0, 8'h74, 8'h9D, 5);
    wait_idle(0);
    offer(0, 8'hFF, 8'hFF, 0);
    wait_idle(0);
    offer(0, 8'h00, 8'hFF, 8);
    wait_idle(0);
    offer(1, 8'hA9, 8'h7B, 4);
    @(negedge clk);
    chk("load_core_rst", int'(core_rst[1]), 1);
    chk("load_g_slice", int'(g_sl[1]), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("send_g_slice%0d", k), int'(g_sl[1]), gx[k]);
      chk($sformatf("send_e_slice%0d", k), int'(e_sl[1]), ex[k]);
      chk("send_core_rst", int'(core_rst[1]), 0);
    end
    @(negedge clk);
    chk("wait_g_slice", int'(g_sl[1]), 0);
    wait_idle(1);
    res_ready[0] = 1'b0;
    offer(0, 8'hA9, 8'h7B, 4);
    n = 0;
    @(negedge clk);
    while (!res_valid[0] && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("bp_valid_seen", int'(res_valid[0]), 1);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      in_valid[0] = j[0];
      g_word[0] = 8'h00;
      e_word[0] = 8'hFF;
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    res_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_valid", int'(res_valid[0]), 0);
    chk("bp_release_ready", int'(in_ready[0]), 1);
    @(posedge clk);
    #1;
    offer(0, 8'h74, 8'h9D, 5);
    wait_idle(0);
    offer(1, 8'hA9, 8'h7B, 4);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q[1].delete();
    acc_q[1].delete();
    @(negedge clk);
    chk("abort_core_rst", int'(core_rst[1]), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_res_valid", int'(res_valid[1]), 0);
    chk("abort_in_ready", int'(in_ready[1]), 1);
    chk("abort_g_slice", int'(g_sl[1]), 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    offer(1, 8'hFF, 8'h00, 8);
    wait_idle(1);
    prev = 0;
    for (int p = 0; p < 3; p++) begin
      g_word[0] = bg[p];
      e_word[0] = be[p];
      in_valid[0] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready[0] && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (n >= 50) chk("b2b_timeout", n, 0);
      exp_q[0].push_back(bx[p]);
      if (p > 0) chk("b2b_interval", cyc - prev, 5);
      prev = cyc;
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    wait_idle(0);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q[0].size() + exp_q[1].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
